// File: rtl/sd_cmd_tx_ctrl.sv
// SD command-line transmit controller: builds the 48-bit command frame and paces
// an external 8-bit parallel-to-serial shift register (shifts in 1s, MSB out).
module sd_cmd_tx_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        cmd_done,
    output logic        load_enable,
    output logic        shift_enable,
    output logic [7:0]  parallel_in
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [5:0]       idx_q;
    logic [31:0]      arg_q;
    logic [DIV_W-1:0] divider;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_idx;
    logic [6:0]       crc;
    logic [7:0]       shadow;
    logic [6:0]       crc_next;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc_in, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc_in[6];
        crc7_step = {crc_in[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0]  sel,
                                              input logic [5:0]  idx,
                                              input logic [31:0] arg,
                                              input logic [6:0]  crc_val);
        case (sel)
            3'd0:    frame_byte = {2'b01, idx};
            3'd1:    frame_byte = arg[31:24];
            3'd2:    frame_byte = arg[23:16];
            3'd3:    frame_byte = arg[15:8];
            3'd4:    frame_byte = arg[7:0];
            3'd5:    frame_byte = {crc_val, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    endfunction

    // The bit on the line is always the MSB of the shadow copy of the shift register.
    assign crc_next = crc7_step(crc, shadow[7]);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shadow <= 8'hFF;
        end else if (load_enable) begin
            shadow <= parallel_in;
        end else if (shift_enable) begin
            shadow <= {shadow[6:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx_q        <= '0;
            arg_q        <= '0;
            divider      <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            crc          <= '0;
            busy         <= 1'b0;
            cmd_done     <= 1'b0;
            load_enable  <= 1'b0;
            shift_enable <= 1'b0;
            parallel_in  <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    cmd_done     <= 1'b0;
                    load_enable  <= 1'b0;
                    shift_enable <= 1'b0;
                    parallel_in  <= 8'hFF;
                    if (cmd_start) begin
                        idx_q       <= cmd_index;
                        arg_q       <= cmd_arg;
                        busy        <= 1'b1;
                        load_enable <= 1'b1;
                        parallel_in <= {2'b01, cmd_index};
                        byte_idx    <= '0;
                        bit_cnt     <= '0;
                        divider     <= '0;
                        crc         <= '0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    load_enable <= 1'b0;
                    parallel_in <= 8'hFF;
                    divider     <= divider + DIV_W'(1);
                    state       <= SHIFT;
                end
                SHIFT: begin
                    load_enable  <= 1'b0;
                    shift_enable <= 1'b0;
                    parallel_in  <= 8'hFF;
                    // Outputs are registered, so the last divider count launches the
                    // pulse that lands in the first cycle of the next bit period.
                    if (divider == DIV_MAX) begin
                        divider <= '0;
                        if (byte_idx < 3'd5) begin
                            crc <= crc_next;
                        end
                        if (bit_cnt != 3'd7) begin
                            shift_enable <= 1'b1;
                            bit_cnt      <= bit_cnt + 3'd1;
                        end else if (byte_idx != 3'd5) begin
                            load_enable <= 1'b1;
                            parallel_in <= frame_byte(byte_idx + 3'd1, idx_q, arg_q, crc_next);
                            byte_idx    <= byte_idx + 3'd1;
                            bit_cnt     <= '0;
                        end else begin
                            load_enable <= 1'b1;
                            parallel_in <= 8'hFF;
                            cmd_done    <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        divider <= divider + DIV_W'(1);
                    end
                end
                DONE: begin
                    cmd_done    <= 1'b0;
                    load_enable <= 1'b0;
                    parallel_in <= 8'hFF;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_cmd_tx_ctrl.md
Name: sd_cmd_tx_ctrl

Overview:
Upstream controller for the SD command-line parallel-to-serial shift register. It is instantiated with NUM_BITS=8 and SHIFT_MSB=1, which shift in 1s and reset to all-ones.
- Accepts a command index and 32-bit argument.
- Builds the 48-bit SD command frame: start bit, transmission bit, index, argument, CRC7 and end bit.
- Paces the shift register with load_enable, shift_enable and a parallel byte, one bit per CLK_DIV system clocks.
- Sits between the SD transaction FSM and the command-line shift register.

Parameters:
- CLK_DIV, 4: system clocks per SD bit period. Legal range is CLK_DIV >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- cmd_start  input  1  single-cycle request to send a command.
- cmd_index  input  6  command index; captured on accept.
- cmd_arg  input  32  command argument; captured on accept.
- busy  output  1  frame in progress; new requests are ignored while high.
- cmd_done  output  1  one-cycle pulse when the frame is complete.
- load_enable  output  1  to shift register: load parallel_in.
- shift_enable  output  1  to shift register: shift one bit toward the MSB.
- parallel_in  output  8  byte to load into the shift register.

Behaviour:
- Reset values: busy=0, cmd_done=0, load_enable=0, shift_enable=0, parallel_in=8'hFF, all internal counters and the CRC cleared. Reset is honoured mid-frame: return to IDLE immediately with no done pulse.
- Frame bytes B0..B5, sent MSB first:
  - B0 = {1'b0, 1'b1, cmd_index}.
  - B1..B4 = cmd_arg[31:24], [23:16], [15:8], [7:0].
  - B5 = {CRC7, 1'b1}.
- CRC7: polynomial x^7+x^3+1, init 0, computed over the 40 bits of B0..B4 in transmit order. It is updated once per bit period with the bit currently presented, which is the MSB of an internal shadow copy of the shift register.
- States and transitions:
  - IDLE: busy=0. cmd_start=1 is an accept; it captures cmd_index and cmd_arg and moves to LOAD.
  - LOAD: one cycle. load_enable=1, parallel_in=B0, byte_idx=0, bit_cnt=0, divider=0. Moves to SHIFT.
  - SHIFT: divider counts 0..CLK_DIV-1, and the bit boundary occurs when divider=CLK_DIV-1. At a boundary:
    - bit_cnt<7: shift_enable=1 for one cycle, bit_cnt+1.
    - bit_cnt=7 and byte_idx<5: load_enable=1, parallel_in=next byte, byte_idx+1, bit_cnt=0.
    - bit_cnt=7 and byte_idx=5: load_enable=1, parallel_in=8'hFF so the line idles high, cmd_done=1, then go to IDLE.
- Never assert load_enable and shift_enable together. parallel_in is 8'hFF whenever load_enable=0.
- Timing: accept in cycle T, first load in cycle T+1, final 8'hFF load and cmd_done in cycle T+1+48*CLK_DIV. Each frame bit is held on serial_out for exactly CLK_DIV cycles.
- busy is 1 from cycle T+1 through the cmd_done cycle inclusive.
- cmd_start while busy=1 is ignored, including in the cmd_done cycle. A back-to-back request is accepted no earlier than the cycle after cmd_done.
- Inputs are sampled only on accept; changing them mid-frame has no effect.
- Counter widths: divider is $clog2(CLK_DIV) bits, bit_cnt 3 bits, byte_idx 3 bits; none wrap outside the stated ranges.

Test Plan:
- Reset behaviour: assert n_rst=0 mid-frame (after B2 loaded), CLK_DIV=4 -> outputs return to reset values immediately; serial_out=1 from the shift register; no cmd_done; a new cmd_start after release sends a complete frame.
- CMD0: cmd_index=0, cmd_arg=0 -> serial stream 0x40 00 00 00 00 95; cmd_done at T+1+192.
- CMD8: cmd_index=8, cmd_arg=0x000001AA -> stream 0x48 00 00 01 AA 87 (CRC7=0x43); each bit held 4 cycles.
- Busy rejection: cmd_start pulsed mid-frame with different index/arg, and again in the cmd_done cycle -> both ignored, the frame is unchanged, exactly one cmd_done.
- Back-to-back: CMD0 then cmd_start the cycle after cmd_done with CMD8 -> second frame load begins 2 cycles after the first cmd_done; both frames are correct.
- CLK_DIV=2: CMD0 -> same bytes; total 96 cycles from first load to cmd_done; load_enable and shift_enable are never high together.
